// File: rtl/de_pipe_calcpc.sv
// Decode-to-execute control-flow stage: valid/ready handshake with a 2-entry skid buffer,
// flush with saturating drop count, and jump/branch codes squashed to 0 on bubbles.
module de_pipe_calcpc #(
    parameter int unsigned TAG_W  = 1,
    parameter int unsigned PC_W   = 13,
    parameter int unsigned IMM_W  = 13,
    parameter int unsigned JUMP_W = 2,
    parameter int unsigned BR_W   = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  inst_numberD,
    input  logic [PC_W-1:0]   pcD,
    input  logic [IMM_W-1:0]  immD,
    input  logic [JUMP_W-1:0] jump_codeD,
    input  logic [BR_W-1:0]   branch_codeD,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  inst_numberE,
    output logic [PC_W-1:0]   pcE,
    output logic [IMM_W-1:0]  immE,
    output logic [JUMP_W-1:0] jump_codeE,
    output logic [BR_W-1:0]   branch_codeE,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned P_W = TAG_W + PC_W + IMM_W + JUMP_W + BR_W;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q, state_d;
    logic [P_W-1:0]   m_q, m_d, s_q, s_d;
    logic [P_W-1:0]   in_bundle;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             m_valid, s_valid, acc, deq;
    logic [1:0]       drop_add;
    logic [CNT_W+1:0] drop_sum;

    assign in_bundle = {inst_numberD, pcD, immD, jump_codeD, branch_codeD};
    assign m_valid   = (state_q != StEmpty);
    assign s_valid   = (state_q == StFull);
    // in_ready comes straight from state, so it never depends on out_ready
    assign acc       = in_valid & ~s_valid;
    assign deq       = m_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= StEmpty;
            m_q     <= '0;
            s_q     <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d = StOne;
                        m_d     = in_bundle;
                    end
                end
                StOne: begin
                    if (acc && deq) begin
                        m_d = in_bundle;
                    end else if (acc) begin
                        state_d = StFull;
                        s_d     = in_bundle;
                    end else if (deq) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (deq) begin
                        state_d = StOne;
                        m_d     = s_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Drops: M not taken by execute this cycle, anything in S, and a same-cycle accept.
    always_comb begin
        drop_add = 2'(m_valid & ~deq) + 2'(s_valid) + 2'(acc);
        drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, drop_add};
        drop_d   = drop_q;
        if (flush) begin
            drop_d = (drop_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        out_valid = m_valid;
        in_ready  = ~s_valid;
        {inst_numberE, pcE, immE, jump_codeE, branch_codeE} = m_q;
        if (!m_valid) begin
            jump_codeE   = '0;
            branch_codeE = '0;
        end
        occupancy = {1'b0, m_valid} + {1'b0, s_valid};
        drop_cnt  = drop_q;
    end

endmodule

// File: doc/de_pipe_calcpc.md
Name: de_pipe_calcpc

Overview:
Decode-to-execute pipeline stage for the control-flow bundle: instruction tag, PC, immediate, jump code and branch code. It is a parametrised successor of the single-register D/E jump-calc stage. It replaces the stall-zeroes-codes scheme with a valid/ready handshake, a 2-entry skid buffer, a flush, and bubble signalling. It sits between the decoder and the execute-stage PC/branch-target calculator.

Parameters:
TAG_W, 1, instruction tag width (inst_number)
PC_W, 13, PC width
IMM_W, 13, immediate width
JUMP_W, 2, jump code width; 0 means no jump
BR_W, 3, branch code width; 0 means no branch
CNT_W, 8, width of the saturating flush-drop counter

Ports:
CLK  in  1  clock, rising edge
NRST  in  1  synchronous active-low reset
in_valid  in  1  decode bundle valid
in_ready  out  1  stage can accept a bundle
inst_numberD  in  TAG_W  instruction tag
pcD  in  PC_W  PC
immD  in  IMM_W  immediate
jump_codeD  in  JUMP_W  jump code
branch_codeD  in  BR_W  branch code
flush  in  1  discard all held and incoming bundles
out_valid  out  1  execute bundle valid
out_ready  in  1  execute consumes the bundle
inst_numberE  out  TAG_W  tag
pcE  out  PC_W  PC
immE  out  IMM_W  immediate
jump_codeE  out  JUMP_W  jump code; forced 0 when !out_valid
branch_codeE  out  BR_W  branch code; forced 0 when !out_valid
occupancy  out  2  entries held (0..2)
drop_cnt  out  CNT_W  saturating count of bundles killed by flush

Behaviour:
- Interface: one clock CLK. Reset NRST is synchronous and active-low. All state updates on the rising edge of CLK.
- Storage: main entry M drives the outputs. Skid entry S holds overflow. States: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1).
- in_ready = !S_valid. It is registered state, not combinational on out_ready. It is 1 in EMPTY and ONE, and 0 in FULL.
- acc = in_valid & in_ready. deq = out_valid & out_ready. out_valid = M_valid.
- Transitions when flush=0:
  - EMPTY + acc: go to ONE; M <= input. Latency is 1 cycle from accept to out_valid.
  - ONE + acc + deq: stay in ONE; M <= input.
  - ONE + acc + !deq: go to FULL; S <= input; M is held.
  - ONE + !acc + deq: go to EMPTY.
  - FULL + deq: go to ONE; M <= S. No accept is possible in FULL.
  - No acc and no deq: all state is held, and outputs are stable while out_valid & !out_ready.
- Order: bundles leave in exactly the order they were accepted. There is no loss or duplication.
- flush=1:
  - Next cycle M_valid=0, S_valid=0, so the state is EMPTY.
  - An input accepted in the same cycle is discarded.
  - A deq in the same cycle still counts as consumed by the execute stage.
  - flush overrides acc and deq for state purposes.
- drop_cnt: on flush, add (M_valid & !deq) + S_valid + acc. The counter saturates at 2^CNT_W-1 and never wraps.
- Bubble: when out_valid=0, jump_codeE=0 and branch_codeE=0. inst_numberE, pcE and immE keep the last M payload (don't-care).
- occupancy = M_valid + S_valid.
- Reset (NRST=0 at an edge): M_valid=0, S_valid=0, all payload registers 0, drop_cnt=0.
  - Outputs after reset: in_ready=1, out_valid=0, occupancy=0, every E output 0.
  - Reset has priority over flush and the handshake. Mid-operation reset discards everything and does not count drops.
- Payload is copied bit-exact. There is no arithmetic on PC or immediate, and no sign extension.

Test Plan:
- Reset, then stream with out_ready=1: inputs (tag,pc,imm,jump,branch) = (1,0x010,0x004,1,0), (0,0x014,0x1FFC,0,5) on consecutive cycles -> each appears one cycle later with out_valid=1 and in_ready stays 1.
- Backpressure: out_ready=0, push A=pc 0x020 then B=pc 0x024 -> occupancy=2, in_ready=0, outputs stay A. Raise out_ready -> A, then B, then out_valid=0 with jump/branch=0.
- Flush in FULL while in_valid=1 (in_ready=0) -> next cycle occupancy=0, out_valid=0, drop_cnt=2. Flush in ONE with out_ready=1 and a simultaneous accept -> drop_cnt +1, the incoming bundle is discarded, and the M bundle counts as consumed.
- CNT_W=2: issue 5 flushes, each with one held entry -> drop_cnt=3 (saturated).
- Reset asserted while FULL and flush=1 -> next cycle all outputs 0, drop_cnt=0, in_ready=1.
- Randomised in_valid/out_ready with PC_W=32, IMM_W=21 -> scoreboard confirms in-order, lossless delivery, and jump/branch=0 on every cycle where out_valid=0.
